// File: rtl/burst_read_arbiter.sv
// Burst read controller: drains NUM_CH sample FIFOs into the Ethernet TX path
// in BURST_LEN-word bursts separated by PAUSE_LEN idle cycles, with backpressure.
module burst_read_arbiter #(
  parameter int NUM_CH    = 2,
  parameter int BURST_LEN = 1024,
  parameter int PAUSE_LEN = 8192,
  parameter int CNT_W     = 16,
  parameter int RR_MODE   = 0,
  localparam int AW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              full,
  input  logic [NUM_CH-1:0] empty,
  input  logic              eth_ready,
  output logic              eth_en,
  output logic [NUM_CH-1:0] rd_en,
  output logic [AW-1:0]     addr,
  output logic              burst_done,
  output logic              busy
);

  localparam int PADW = 1 << AW;
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0] PAUSE_LAST = CNT_W'(PAUSE_LEN - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]    ptr_q, ptr_d;

  logic [PADW-1:0]  avail;
  logic [AW-1:0]    sel, idx;
  logic             found;
  logic             any_data, all_empty;

  assign any_data  = |(~empty);
  assign all_empty = &empty;

  // Scan starts at ptr in round-robin mode, at 0 in fixed-priority mode.
  always_comb begin
    avail = PADW'(~empty);
    sel   = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (RR_MODE != 0) idx = AW'((32'(ptr_q) + k) % NUM_CH);
      else              idx = AW'(k);
      if (!found && avail[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    eth_en     = 1'b0;
    rd_en      = '0;
    addr       = '0;
    burst_done = 1'b0;
    busy       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (full && any_data) begin
          state_d = S_READ;
          cnt_d   = '0;
        end
      end
      S_READ: begin
        busy = 1'b1;
        addr = sel;
        if (all_empty) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (eth_ready) begin
          eth_en = 1'b1;
          rd_en  = NUM_CH'(1) << sel;
          // Re-locking on every read equals re-locking on the first substitute read.
          if (RR_MODE != 0) ptr_d = sel;
          if (cnt_q == BURST_LAST) begin
            burst_done = 1'b1;
            state_d    = S_PAUSE;
            cnt_d      = '0;
            if (RR_MODE != 0) ptr_d = AW'((32'(sel) + 1) % NUM_CH);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_PAUSE: begin
        busy = 1'b1;
        addr = sel;
        if (all_empty) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == PAUSE_LAST) begin
          state_d = S_READ;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule

// File: tb/tb_burst_read_arbiter.sv
// Directed table-driven bench: 2-channel fixed-priority and 4-channel round-robin
// instances, plus an asynchronous mid-burst reset sequence.
module tb_burst_read_arbiter;

  logic       clk;
  logic       rstn;

  logic       a_full, a_rdy, a_en, a_bd, a_busy;
  logic [1:0] a_emp, a_rd;
  logic [0:0] a_addr;

  logic       b_full, b_rdy, b_en, b_bd, b_busy;
  logic [3:0] b_emp, b_rd;
  logic [1:0] b_addr;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       full;
    logic [3:0] emp;
    logic       rdy;
    logic [8:0] exp;   // {eth_en, rd_en[3:0], addr[1:0], burst_done, busy}
  } vec_t;

  vec_t ta[$];
  vec_t tb[$];

  burst_read_arbiter #(.NUM_CH(2), .BURST_LEN(4), .PAUSE_LEN(3), .CNT_W(4), .RR_MODE(0)) dut_a (
    .clk(clk), .rstn(rstn), .full(a_full), .empty(a_emp), .eth_ready(a_rdy),
    .eth_en(a_en), .rd_en(a_rd), .addr(a_addr), .burst_done(a_bd), .busy(a_busy)
  );

  burst_read_arbiter #(.NUM_CH(4), .BURST_LEN(4), .PAUSE_LEN(3), .CNT_W(4), .RR_MODE(1)) dut_b (
    .clk(clk), .rstn(rstn), .full(b_full), .empty(b_emp), .eth_ready(b_rdy),
    .eth_en(b_en), .rd_en(b_rd), .addr(b_addr), .burst_done(b_bd), .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic f, input logic [3:0] e, input logic r,
                              input logic en, input logic [3:0] rd, input logic [1:0] ad,
                              input logic bd, input logic bs);
    vec_t v;
    v.full = f;
    v.emp  = e;
    v.rdy  = r;
    v.exp  = {en, rd, ad, bd, bs};
    return v;
  endfunction

  function automatic logic [8:0] pa();
    return {a_en, 2'b00, a_rd, 1'b0, a_addr, a_bd, a_busy};
  endfunction

  function automatic logic [8:0] pb();
    return {b_en, b_rd, b_addr, b_bd, b_busy};
  endfunction

  task automatic check(input string nm, input int idx, input logic [8:0] got, input logic [8:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got en=%b rd=%b addr=%0d bd=%b busy=%b, expected en=%b rd=%b addr=%0d bd=%b busy=%b",
               nm, idx, got[8], got[7:4], got[3:2], got[1], got[0],
               exp[8], exp[7:4], exp[3:2], exp[1], exp[0]);
    end
  endtask

  initial begin
    // Table A: NUM_CH=2, fixed priority
    ta.push_back(mk(0,0,1, 0,0,0,0,0));
    ta.push_back(mk(1,0,1, 0,0,0,0,0));
    ta.push_back(mk(0,0,1, 1,1,0,0,1));
    ta.push_back(mk(1,0,1, 1,1,0,0,1));
    ta.push_back(mk(0,0,1, 1,1,0,0,1));
    ta.push_back(mk(0,0,1, 1,1,0,1,1));
    ta.push_back(mk(0,0,1, 0,0,0,0,1));
    ta.push_back(mk(0,0,1, 0,0,0,0,1));
    ta.push_back(mk(0,0,1, 0,0,0,0,1));
    ta.push_back(mk(0,0,1, 1,1,0,0,1));
    ta.push_back(mk(0,0,1, 1,1,0,0,1));
    ta.push_back(mk(0,1,1, 1,2,1,0,1));
    ta.push_back(mk(0,1,1, 1,2,1,1,1));
    ta.push_back(mk(0,1,1, 0,0,1,0,1));
    ta.push_back(mk(0,1,0, 0,0,1,0,1));
    ta.push_back(mk(0,1,1, 0,0,1,0,1));
    ta.push_back(mk(0,1,1, 1,2,1,0,1));
    ta.push_back(mk(0,1,0, 0,0,1,0,1));
    ta.push_back(mk(0,1,1, 1,2,1,0,1));
    ta.push_back(mk(0,1,0, 0,0,1,0,1));
    ta.push_back(mk(0,1,1, 1,2,1,0,1));
    ta.push_back(mk(0,1,0, 0,0,1,0,1));
    ta.push_back(mk(0,1,1, 1,2,1,1,1));
    ta.push_back(mk(0,1,0, 0,0,1,0,1));
    ta.push_back(mk(0,1,1, 0,0,1,0,1));
    ta.push_back(mk(0,1,0, 0,0,1,0,1));
    ta.push_back(mk(0,1,1, 1,2,1,0,1));
    ta.push_back(mk(0,3,1, 0,0,0,0,1));
    ta.push_back(mk(0,3,1, 0,0,0,0,0));
    ta.push_back(mk(1,1,1, 0,0,0,0,0));
    ta.push_back(mk(0,1,1, 1,2,1,0,1));
    ta.push_back(mk(0,1,1, 1,2,1,0,1));
    ta.push_back(mk(0,1,1, 1,2,1,0,1));
    ta.push_back(mk(0,1,1, 1,2,1,1,1));
    ta.push_back(mk(0,1,1, 0,0,1,0,1));
    ta.push_back(mk(0,3,1, 0,0,0,0,1));
    ta.push_back(mk(1,3,1, 0,0,0,0,0));
    ta.push_back(mk(0,0,1, 0,0,0,0,0));
    ta.push_back(mk(1,0,1, 0,0,0,0,0));
    ta.push_back(mk(0,0,1, 1,1,0,0,1));
    ta.push_back(mk(0,1,1, 1,2,1,0,1));
    ta.push_back(mk(0,2,1, 1,1,0,0,1));
    ta.push_back(mk(0,0,1, 1,1,0,1,1));

    // Table B: NUM_CH=4, round-robin, FIFO 2 empty
    tb.push_back(mk(1,4,1, 0,0,0,0,0));
    for (int i = 0; i < 3; i++) tb.push_back(mk(0,4,1, 1,1,0,0,1));
    tb.push_back(mk(0,4,1, 1,1,0,1,1));
    for (int i = 0; i < 3; i++) tb.push_back(mk(0,4,1, 0,0,1,0,1));
    for (int i = 0; i < 3; i++) tb.push_back(mk(0,4,1, 1,2,1,0,1));
    tb.push_back(mk(0,4,1, 1,2,1,1,1));
    for (int i = 0; i < 3; i++) tb.push_back(mk(0,4,1, 0,0,3,0,1));
    for (int i = 0; i < 3; i++) tb.push_back(mk(0,4,1, 1,8,3,0,1));
    tb.push_back(mk(0,4,1, 1,8,3,1,1));
    for (int i = 0; i < 3; i++) tb.push_back(mk(0,4,1, 0,0,0,0,1));
    for (int i = 0; i < 3; i++) tb.push_back(mk(0,4,1, 1,1,0,0,1));
    tb.push_back(mk(0,4,1, 1,1,0,1,1));
    for (int i = 0; i < 3; i++) tb.push_back(mk(0,5,1, 0,0,1,0,1));
    tb.push_back(mk(0,5,1, 1,2,1,0,1));
    tb.push_back(mk(0,5,1, 1,2,1,0,1));
    tb.push_back(mk(0,7,1, 1,8,3,0,1));
    tb.push_back(mk(0,5,1, 1,8,3,1,1));
    for (int i = 0; i < 3; i++) tb.push_back(mk(0,5,1, 0,0,1,0,1));
    for (int i = 0; i < 3; i++) tb.push_back(mk(0,5,1, 1,2,1,0,1));
    tb.push_back(mk(0,5,1, 1,2,1,1,1));

    rstn   = 1'b0;
    a_full = 1'b0; a_emp = 2'b11;   a_rdy = 1'b0;
    b_full = 1'b0; b_emp = 4'b1111; b_rdy = 1'b0;
    #1;
    check("reset_a", 0, pa(), 9'd0);
    check("reset_b", 0, pb(), 9'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < ta.size(); i++) begin
      @(negedge clk);
      a_full = ta[i].full; a_emp = ta[i].emp[1:0]; a_rdy = ta[i].rdy;
      #1;
      check("tblA", i, pa(), ta[i].exp);
    end
    @(negedge clk);
    a_rdy = 1'b0;

    for (int i = 0; i < tb.size(); i++) begin
      @(negedge clk);
      b_full = tb[i].full; b_emp = tb[i].emp; b_rdy = tb[i].rdy;
      #1;
      check("tblB", i, pb(), tb[i].exp);
    end

    // Let B finish its gap stalled, then hit both mid-read with an async reset
    repeat (3) begin
      @(negedge clk);
      b_rdy = 1'b0;
    end
    @(negedge clk);
    a_rdy = 1'b1; a_emp = 2'b00;
    b_rdy = 1'b1; b_emp = 4'b0101;
    #1;
    check("pre_rst_a", 0, pa(), {1'b1, 4'b0001, 2'd0, 1'b0, 1'b1});
    check("pre_rst_b", 0, pb(), {1'b1, 4'b1000, 2'd3, 1'b0, 1'b1});
    #1 rstn = 1'b0;
    #1;
    check("async_rst_a", 0, pa(), 9'd0);
    check("async_rst_b", 0, pb(), 9'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    a_full = 1'b1; b_full = 1'b1; b_emp = 4'b0000;
    #1;
    check("post_rst_idle_a", 0, pa(), 9'd0);
    check("post_rst_idle_b", 0, pb(), 9'd0);
    @(negedge clk);
    a_full = 1'b0; b_full = 1'b0;
    #1;
    check("post_rst_read_a", 0, pa(), {1'b1, 4'b0001, 2'd0, 1'b0, 1'b1});
    check("post_rst_read_b", 0, pb(), {1'b1, 4'b0001, 2'd0, 1'b0, 1'b1});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
